// File: rtl/db15_joy_tx.sv
// Device-side DB15 serial joystick responder: presents two player words bit-serially, active-low.
// Optional link-loss timeout is enabled by defining DB15_JOY_TX_TIMEOUT_EN.
module db15_joy_tx #(
  parameter int PLAYER_BITS    = 12,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PLAYER_BITS-1:0] joystick1,
  input  logic [PLAYER_BITS-1:0] joystick2,
  input  logic                   joy_clk,
  input  logic                   joy_load,
  output logic                   joy_data,
  output logic [4:0]             bit_idx,
  output logic                   frame_done,
  output logic                   link_active
);

  localparam int         FRAME_BITS = 2 * PLAYER_BITS;
  localparam logic [4:0] IDX_LAST   = 5'(FRAME_BITS - 1);
  localparam logic [4:0] IDX_END    = 5'(FRAME_BITS);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || TIMEOUT_CYCLES < 1 || FRAME_BITS > 31) begin : g_param_check
    $error("db15_joy_tx: parameter out of range");
  end

  typedef enum logic [1:0] {
    ST_IDLE,     // after reset, waiting for a first load
    ST_LOAD,     // initiator holds joy_load low
    ST_SHIFT,    // frame in progress
    ST_OVERRUN   // all frame bits delivered, reporting released
  } state_e;

  // Pin synchronizers; one extra registered copy of the last stage drives edge detection.
  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] load_sync_q;
  logic                   clk_prev_q;
  logic                   load_prev_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync_q  <= '1;
      load_sync_q <= '1;
      clk_prev_q  <= 1'b1;
      load_prev_q <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], joy_clk};
      load_sync_q <= {load_sync_q[SYNC_STAGES-2:0], joy_load};
      clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
      load_prev_q <= load_sync_q[SYNC_STAGES-1];
    end
  end

  logic clk_s;
  logic load_s;
  logic clk_rise;

  assign clk_s    = clk_sync_q[SYNC_STAGES-1];
  assign load_s   = load_sync_q[SYNC_STAGES-1];
  assign clk_rise = clk_s & ~clk_prev_q;

`ifdef DB15_JOY_TX_TIMEOUT_EN
  localparam int                CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  logic             load_fall;
  logic [CNT_W-1:0] idle_cnt_q;
  logic [CNT_W-1:0] idle_cnt_d;

  assign load_fall = ~load_s & load_prev_q;

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (load_fall) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != CNT_MAX) begin
      idle_cnt_d = idle_cnt_q + CNT_W'(1);
    end
  end

  // Starts saturated so the link only comes up on the first load after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt_q <= CNT_MAX;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end

  assign link_active = (idle_cnt_q != CNT_MAX);
`else
  assign link_active = 1'b1;
`endif

  state_e                state_q;
  state_e                state_d;
  logic [FRAME_BITS-1:0] sr_q;
  logic [FRAME_BITS-1:0] sr_d;
  logic [4:0]            bit_idx_q;
  logic [4:0]            bit_idx_d;
  logic                  frame_done_q;
  logic                  frame_done_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    bit_idx_d    = bit_idx_q;
    frame_done_d = 1'b0;

    if (!load_s) begin
      // Load wins over a coincident clock edge; the last load cycle is the frame snapshot.
      state_d   = ST_LOAD;
      sr_d      = {~joystick2, ~joystick1};
      bit_idx_d = '0;
    end else if (clk_rise && state_q != ST_IDLE) begin
      sr_d = {1'b1, sr_q[FRAME_BITS-1:1]};
      if (bit_idx_q != IDX_END) begin
        bit_idx_d = bit_idx_q + 5'd1;
      end
      if (bit_idx_q == IDX_LAST) begin
        frame_done_d = 1'b1;
        state_d      = ST_OVERRUN;
      end else if (state_q == ST_LOAD) begin
        state_d = ST_SHIFT;
      end
    end else if (state_q == ST_LOAD) begin
      state_d = ST_SHIFT;
    end

`ifdef DB15_JOY_TX_TIMEOUT_EN
    if (!link_active) begin
      sr_d = '1;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      sr_q         <= '1;
      bit_idx_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      bit_idx_q    <= bit_idx_d;
      frame_done_q <= frame_done_d;
    end
  end

  // sr[0] is the bit on the wire; in load it tracks ~joystick1[0] one register behind.
  assign joy_data   = sr_q[0];
  assign bit_idx    = bit_idx_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_db15_joy_tx.sv
// Directed self-checking bench for db15_joy_tx: frame order, capture, overrun, abort, reset and timeout.
module tb_db15_joy_tx;

  localparam int PB = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [PB-1:0] joystick1 = '0;
  logic [PB-1:0] joystick2 = '0;
  logic          joy_clk = 1'b0;
  logic          joy_load = 1'b1;
  logic          joy_data;
  logic [4:0]    bit_idx;
  logic          frame_done;
  logic          link_active;

  int n_tests = 0;
  int n_fail  = 0;
  int fd_cnt  = 0;

  db15_joy_tx #(
    .PLAYER_BITS    (PB),
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .joystick1   (joystick1),
    .joystick2   (joystick2),
    .joy_clk     (joy_clk),
    .joy_load    (joy_load),
    .joy_data    (joy_data),
    .bit_idx     (bit_idx),
    .frame_done  (frame_done),
    .link_active (link_active)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycles(3);
    reset = 1'b0;
    cycles(2);
  endtask

  task automatic clk_edge();
    joy_clk = 1'b1;
    cycles(8);
    joy_clk = 1'b0;
    cycles(8);
  endtask

  // bits[0] is the bit on the wire before any edge, bits[k] the bit after edge k.
  task automatic read_stream(input int n, output logic [63:0] bits);
    bits    = '1;
    bits[0] = joy_data;
    for (int k = 1; k <= n; k++) begin
      clk_edge();
      bits[k] = joy_data;
    end
  endtask

  task automatic load_frame(input logic [PB-1:0] p1, input logic [PB-1:0] p2);
    joystick1 = p1;
    joystick2 = p2;
    joy_load  = 1'b0;
    cycles(10);
    joy_load  = 1'b1;
    cycles(4);
  endtask

  logic [63:0] bits;
  int          fd0;

  initial begin
    do_reset();
    check("rst_joy_data", 32'(joy_data), 32'h1);
    check("rst_bit_idx", 32'(bit_idx), 32'h0);
    check("rst_frame_done", 32'(frame_done), 32'h0);

`ifdef DB15_JOY_TX_TIMEOUT_EN
    check("to_rst_link", 32'(link_active), 32'h0);
    joystick1 = 12'hFFF;
    joystick2 = 12'hFFF;
    joy_load  = 1'b0;
    cycles(4);
    check("to_link_up", 32'(link_active), 32'h1);
    joy_load = 1'b1;
    cycles(4);
    check("to_data_live", 32'(joy_data), 32'h0);
    cycles(110);
    check("to_link_lost", 32'(link_active), 32'h0);
    check("to_data_released", 32'(joy_data), 32'h1);
    joy_load = 1'b0;
    cycles(4);
    check("to_link_relink", 32'(link_active), 32'h1);
    joy_load = 1'b1;
    cycles(4);
`else
    check("rst_link_active", 32'(link_active), 32'h1);

    // Basic frame: p1=0x001, p2=0x800 -> only bit0 and bit23 pressed.
    fd0       = fd_cnt;
    joystick1 = 12'h001;
    joystick2 = 12'h800;
    joy_load  = 1'b0;
    cycles(10);
    check("t1_load_data", 32'(joy_data), 32'h0);
    check("t1_load_idx", 32'(bit_idx), 32'h0);
    joy_load = 1'b1;
    cycles(4);
    read_stream(24, bits);
    check("t1_stream", 32'(bits[23:0]), 32'h7FFFFE);
    check("t1_after_last", 32'(bits[24]), 32'h1);
    check("t1_idx_end", 32'(bit_idx), 32'd24);
    check("t1_frame_done", 32'(fd_cnt - fd0), 32'd1);

    // Capture: input changes after the load has been seen do not reach this frame.
    fd0 = fd_cnt;
    load_frame(12'h001, 12'h800);
    joystick1 = 12'hFFF;
    read_stream(24, bits);
    check("t2_stream_frozen", 32'(bits[23:0]), 32'h7FFFFE);
    check("t2_frame_done", 32'(fd_cnt - fd0), 32'd1);

    // Overrun: 30 edges after one load.
    fd0 = fd_cnt;
    load_frame(12'h001, 12'h800);
    read_stream(30, bits);
    check("t3_stream", 32'(bits[23:0]), 32'h7FFFFE);
    check("t3_overrun_ones", 32'(bits[30:24]), 32'h7F);
    check("t3_idx_sat", 32'(bit_idx), 32'd24);
    check("t3_single_done", 32'(fd_cnt - fd0), 32'd1);

    // Short frame aborted by a load after 7 edges, then a full frame.
    fd0 = fd_cnt;
    load_frame(12'h0A5, 12'h35C);
    read_stream(7, bits);
    check("t4_partial_bits", 32'(bits[7:0]), 32'h5A);
    check("t4_partial_idx", 32'(bit_idx), 32'd7);
    joystick1 = 12'h001;
    joy_load  = 1'b0;
    cycles(4);
    check("t4_live_pressed", 32'(joy_data), 32'h0);
    joystick1 = 12'h000;
    cycles(4);
    check("t4_live_released", 32'(joy_data), 32'h1);
    check("t4_abort_idx", 32'(bit_idx), 32'h0);
    check("t4_abort_no_done", 32'(fd_cnt - fd0), 32'd0);
    joystick1 = 12'h123;
    joystick2 = 12'hABC;
    cycles(4);
    joy_load = 1'b1;
    cycles(4);
    read_stream(24, bits);
    check("t4_stream", 32'(bits[23:0]), 32'h543EDC);
    check("t4_after_last", 32'(bits[24]), 32'h1);
    check("t4_idx_end", 32'(bit_idx), 32'd24);
    check("t4_frame_done", 32'(fd_cnt - fd0), 32'd1);

    // Reset mid-frame at edge 12 with every button pressed.
    fd0 = fd_cnt;
    load_frame(12'hFFF, 12'hFFF);
    read_stream(12, bits);
    check("t5_pre_data", 32'(joy_data), 32'h0);
    check("t5_pre_idx", 32'(bit_idx), 32'd12);
    reset = 1'b1;
    #2;
    check("t5_rst_data", 32'(joy_data), 32'h1);
    check("t5_rst_idx", 32'(bit_idx), 32'h0);
    cycles(2);
    reset = 1'b0;
    cycles(2);
    for (int k = 0; k < 5; k++) begin
      clk_edge();
      check("t5_noload_data", 32'(joy_data), 32'h1);
    end
    check("t5_no_done", 32'(fd_cnt - fd0), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/db15_joy_tx.md
Name: db15_joy_tx

Overview:
- Device-side emulator of the DB15 serial joystick adapter. It is the responder to the joy_db15 reader, which drives JOY_CLK/JOY_LOAD and samples JOY_DATA.
- Takes two parallel player button words and presents them bit-serially, active-low, on a USER_IO-style data line.
- Used for loopback test rigs, and for a MiSTer acting as a DB15 controller source for a second board.
- Sits in the clk_sys/CLK_JOY domain; joy_clk and joy_load are asynchronous pins.

Parameters:
- PLAYER_BITS, 12, bits per player word (order: R,L,D,U,A,B,C,X,Y,Z,Select,Start; bit0 = R).
- SYNC_STAGES, 2, synchronizer flops on joy_clk and joy_load (allowed range 2..4).
- TIMEOUT_CYCLES, 2000000, idle clk cycles without a load before the link is considered lost (optional feature only).

Ports:
- clk  in  1  system clock, 20-50 MHz
- reset  in  1  asynchronous, active-high
- joystick1  in  PLAYER_BITS  player 1 buttons, 1 = pressed
- joystick2  in  PLAYER_BITS  player 2 buttons, 1 = pressed
- joy_clk  in  1  shift clock from initiator; rising edge advances one bit
- joy_load  in  1  low = parallel load/transparent, high = shift
- joy_data  out  1  serial data, active-low (0 = pressed)
- bit_idx  out  5  index of bit currently on joy_data, 0..2*PLAYER_BITS
- frame_done  out  1  one-cycle pulse when the last frame bit has been shifted past
- link_active  out  1  initiator activity seen; tied 1 when the feature is absent

Behaviour:
- Reset (async assert, sync release): shift register all ones (released), joy_data=1, bit_idx=0, frame_done=0, link_active=0 (1 without the feature), synchronizers=1.
- joy_clk and joy_load each pass through SYNC_STAGES flops. Edge detect compares the last sync stage with one further registered copy.
- Pin-to-effect latency: SYNC_STAGES+1 clk cycles; joy_data is registered.
- Shift register sr is 2*PLAYER_BITS wide, holding {~joystick2, ~joystick1}.
- Load state (synced joy_load=0):
  - sr reloads from the inputs every clk cycle.
  - bit_idx=0.
  - joy_data = ~joystick1[0], which is live.
  - joy_clk edges are ignored; load has priority over a simultaneous clock edge.
- Frame capture: the value captured on the last load cycle before joy_load rises is frozen for the whole frame. Later input changes have no effect until the next load.
- Shift state (synced joy_load=1), on each synced joy_clk rising edge:
  - sr shifts right and a 1 fills from the top.
  - bit_idx increments and saturates at 2*PLAYER_BITS.
  - joy_data = sr[0] after the shift.
- Frame order on joy_data: p1 bit0..bit11, then p2 bit0..bit11.
- Overrun: once bit_idx = 2*PLAYER_BITS, further edges keep joy_data=1 (all released) and bit_idx stays saturated.
- frame_done pulses for one cycle on the edge that moves bit_idx from 2*PLAYER_BITS-1 to 2*PLAYER_BITS. It is not repeated on overrun edges.
- Short frame: a load arriving mid-frame aborts the frame silently; no frame_done.
- joy_clk falling edges have no effect.
- Initiator constraint: joy_clk high and low phases, and joy_load pulses, must each last at least SYNC_STAGES+1 clk cycles. Narrower pulses may be missed; this is not detected.
- Reset mid-frame: outputs return to their reset values immediately; the next frame starts only after a fresh load.

Optional Feature:
- Macro: DB15_JOY_TX_TIMEOUT_EN.
- Defined:
  - A counter clears on every synced joy_load falling edge and otherwise counts up, saturating at TIMEOUT_CYCLES.
  - link_active=1 while count < TIMEOUT_CYCLES, and rises on the first load after reset.
  - While link_active=0, sr is forced to all ones and joy_data=1, so no stale presses are reported.
- Undefined: no counter; link_active is constant 1; data path unchanged.

Test Plan:
- Reset, then joystick1=0x001, joystick2=0x800, hold joy_load low 10 cycles, then shift 24 edges (joy_clk 8 cycles per phase) -> joy_data samples are 0 at bit0 and bit23, 1 elsewhere; frame_done pulses once after edge 24; bit_idx=24.
- Change joystick1 to 0xFFF after joy_load rises -> serial stream still reflects the captured 0x001.
- Issue 30 clock edges after one load -> bits 24..29 read 1, bit_idx stays 24, no second frame_done.
- Assert joy_load low after 7 edges, then run a full frame -> bit_idx returns to 0, no frame_done for the aborted frame, new frame is correct.
- Assert reset at edge 12 -> joy_data=1 and bit_idx=0 immediately; edges without a load keep joy_data=1.
- With DB15_JOY_TX_TIMEOUT_EN and TIMEOUT_CYCLES=100, joystick1=0xFFF, no load for 100 cycles -> link_active=0, joy_data=1; a new load -> link_active=1 within SYNC_STAGES+2 cycles.
